// File: rtl/if_pc_pdt.sv
// Instruction-fetch stage: fetch PC, instruction-memory enable and tournament branch
// prediction (bimodal + gshare + chooser), trained and repaired from EX resolution.
module if_pc_pdt #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [31:0]       inst_i,
  output logic [31:0]       pc_o,
  output logic              ce_o,
  output logic              pdt_res_o,
  output logic              which_pdt_o,
  output logic [HIST_W-1:0] history_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_taken_i,
  input  logic              upd_which_i,
  input  logic [HIST_W-1:0] upd_history_i,
  input  logic              upd_mispdt_i,
  input  logic [31:0]       upd_target_i
);

  localparam int unsigned TBL_N   = 1 << IDX_W;
  localparam logic [6:0]  OPC_B   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;
  localparam logic [1:0]  CNT_RST = 2'b01;

  logic [31:0]       pc_q, pc_d;
  logic              ce_q, ce_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [1:0]        bim_q [TBL_N];
  logic [1:0]        bim_d [TBL_N];
  logic [1:0]        gsh_q [TBL_N];
  logic [1:0]        gsh_d [TBL_N];
  logic [1:0]        cho_q [TBL_N];
  logic [1:0]        cho_d [TBL_N];

  logic              is_b_c, is_jal_c, use_gs_c;
  logic [IDX_W-1:0]  bi_idx_c, gs_idx_c, up_bi_c, up_gs_c;
  logic [31:0]       b_imm_c, j_imm_c, tgt_c;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11) res = cnt + 2'd1;
    else if (!up && cnt != 2'b00) res = cnt - 2'd1;
    return res;
  endfunction

  assign is_b_c   = ce_q && (inst_i[6:0] == OPC_B);
  assign is_jal_c = ce_q && (inst_i[6:0] == OPC_JAL);
  assign bi_idx_c = pc_q[IDX_W+1:2];
  assign gs_idx_c = bi_idx_c ^ ghr_q[IDX_W-1:0];
  assign use_gs_c = cho_q[bi_idx_c][1];
  assign up_bi_c  = upd_pc_i[IDX_W+1:2];
  assign up_gs_c  = up_bi_c ^ upd_history_i[IDX_W-1:0];

  assign b_imm_c = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm_c = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign tgt_c   = pc_q + (is_jal_c ? j_imm_c : b_imm_c);

  // Prediction for the instruction currently presented at pc_o
  always_comb begin
    pdt_res_o   = 1'b0;
    which_pdt_o = 1'b0;
    if (is_b_c) begin
      which_pdt_o = use_gs_c;
      pdt_res_o   = use_gs_c ? gsh_q[gs_idx_c][1] : bim_q[bi_idx_c][1];
    end else if (is_jal_c) begin
      pdt_res_o = 1'b1;
    end
  end

  assign history_o = ce_q ? ghr_q : '0;
  assign pc_o      = pc_q;
  assign ce_o      = ce_q;

  // Next PC and global history; a resolved mispredict outranks stall and speculation
  always_comb begin
    pc_d  = pc_q;
    ce_d  = 1'b1;
    ghr_d = ghr_q;
    if (ce_q) begin
      if (upd_mispdt_i)   pc_d = upd_target_i;
      else if (!stall[0]) pc_d = pdt_res_o ? tgt_c : pc_q + 32'd4;
    end
    if (upd_mispdt_i && upd_valid_i)
      ghr_d = {upd_history_i[HIST_W-2:0], upd_taken_i};
    else if (!upd_mispdt_i && !stall[0] && is_b_c)
      ghr_d = {ghr_q[HIST_W-2:0], pdt_res_o};
  end

  // Table training from EX; chooser moves toward the predictor that was right
  always_comb begin
    bim_d = bim_q;
    gsh_d = gsh_q;
    cho_d = cho_q;
    if (upd_valid_i) begin
      bim_d[up_bi_c] = sat_step(bim_q[up_bi_c], upd_taken_i);
      gsh_d[up_gs_c] = sat_step(gsh_q[up_gs_c], upd_taken_i);
      cho_d[up_bi_c] = sat_step(cho_q[up_bi_c], upd_mispdt_i ? !upd_which_i : upd_which_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      ce_q  <= 1'b0;
      ghr_q <= '0;
      for (int unsigned i = 0; i < TBL_N; i++) begin
        bim_q[i] <= CNT_RST;
        gsh_q[i] <= CNT_RST;
        cho_q[i] <= CNT_RST;
      end
    end else begin
      pc_q  <= pc_d;
      ce_q  <= ce_d;
      ghr_q <= ghr_d;
      bim_q <= bim_d;
      gsh_q <= gsh_d;
      cho_q <= cho_d;
    end
  end

  logic unused_c;
  assign unused_c = ^{stall[5:1], upd_pc_i[31:IDX_W+2], upd_pc_i[1:0],
                      upd_history_i[HIST_W-1]};

endmodule
